// File: rtl/bbox_overlay.sv
// Draws a rectangular border over a video stream. The box is tracked once per frame
// from the projection stage, and the last good box is held across a few bad frames.
module bbox_overlay #(
  parameter int          IMG_WIDTH_LINE = 1024,
  parameter int          LINE_W         = 2,
  parameter logic [23:0] BOX_COLOR      = 24'hFF0000,
  parameter int          MISS_MAX       = 3
) (
  input  logic        pixelclk,
  input  logic        reset,
  input  logic        en,
  input  logic [23:0] i_rgb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [11:0] hcount_l,
  input  logic [11:0] hcount_r,
  input  logic [11:0] vcount_l,
  input  logic [11:0] vcount_r,
  output logic [23:0] o_rgb,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        box_valid
);

  localparam int              MW       = $clog2(MISS_MAX + 2);
  localparam logic [11:0]     X_MAX    = 12'(IMG_WIDTH_LINE - 1);
  localparam logic [12:0]     IMG_W13  = 13'(IMG_WIDTH_LINE);
  localparam logic [12:0]     LW_M1    = 13'(LINE_W - 1);
  localparam logic [MW-1:0]   MISS_LIM = MW'(MISS_MAX);
  localparam logic [MW-1:0]   MISS_ONE = MW'(1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  logic [11:0] x_q, x_d, y_q, y_d;
  logic [11:0] hl_q, hl_d, hr_q, hr_d, vl_q, vl_d, vr_q, vr_d;
  logic [MW-1:0] miss_q, miss_d;
  logic        bv_q, bv_d;
  sync_t       sync_in, s1_sync_q, o_sync_q;
  logic        s1_flag_q, s1_flag_d, s1_en_q;
  logic [23:0] s1_rgb_q, o_rgb_q, o_rgb_d;

  logic        frame_end, line_end, cand_ok;
  logic [12:0] x13, y13, hl13, hr13, vl13, vr13;
  logic        in_rows, in_cols, vert_edge, horz_edge;

  assign sync_in = '{hs: i_hs, vs: i_vs, de: i_de};

  always_comb begin
    // Stage-1 sync register doubles as the once-registered i_vs / i_de for edge detection.
    frame_end = s1_sync_q.vs & ~i_vs;
    line_end  = s1_sync_q.de & ~i_de;

    x_d = '0;
    if (i_de) x_d = (x_q < X_MAX) ? x_q + 12'd1 : x_q;

    y_d = y_q;
    if (frame_end)     y_d = '0;
    else if (line_end) y_d = y_q + 12'd1;

    cand_ok = (hcount_l < hcount_r) && (vcount_l < vcount_r) &&
              ({1'b0, hcount_r} < IMG_W13);

    hl_d   = hl_q;
    hr_d   = hr_q;
    vl_d   = vl_q;
    vr_d   = vr_q;
    miss_d = miss_q;
    bv_d   = bv_q;
    if (frame_end) begin
      if (cand_ok) begin
        hl_d   = hcount_l;
        hr_d   = hcount_r;
        vl_d   = vcount_l;
        vr_d   = vcount_r;
        miss_d = '0;
        bv_d   = 1'b1;
      end else begin
        if (miss_q <= MISS_LIM) miss_d = miss_q + MISS_ONE;
        // This miss pushes the count past MISS_MAX: drop the held box.
        if (miss_q >= MISS_LIM) begin
          bv_d = 1'b0;
          hl_d = '0;
          hr_d = '0;
          vl_d = '0;
          vr_d = '0;
        end
      end
    end
  end

  always_comb begin
    x13  = {1'b0, x_q};
    y13  = {1'b0, y_q};
    hl13 = {1'b0, hl_q};
    hr13 = {1'b0, hr_q};
    vl13 = {1'b0, vl_q};
    vr13 = {1'b0, vr_q};

    in_rows   = (y13 >= vl13) && (y13 <= vr13);
    in_cols   = (x13 >= hl13) && (x13 <= hr13);
    vert_edge = ((x13 >= hl13) && (x13 <= hl13 + LW_M1)) ||
                ((x13 + LW_M1 >= hr13) && (x13 <= hr13));
    horz_edge = ((y13 >= vl13) && (y13 <= vl13 + LW_M1)) ||
                ((y13 + LW_M1 >= vr13) && (y13 <= vr13));
    s1_flag_d = bv_q && ((in_rows && vert_edge) || (in_cols && horz_edge));

    o_rgb_d = '0;
    if (s1_sync_q.de) o_rgb_d = (s1_flag_q && s1_en_q) ? BOX_COLOR : s1_rgb_q;
  end

  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      hl_q      <= '0;
      hr_q      <= '0;
      vl_q      <= '0;
      vr_q      <= '0;
      miss_q    <= '0;
      bv_q      <= 1'b0;
      s1_sync_q <= '0;
      s1_flag_q <= 1'b0;
      s1_en_q   <= 1'b0;
      s1_rgb_q  <= '0;
      o_sync_q  <= '0;
      o_rgb_q   <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      hl_q      <= hl_d;
      hr_q      <= hr_d;
      vl_q      <= vl_d;
      vr_q      <= vr_d;
      miss_q    <= miss_d;
      bv_q      <= bv_d;
      s1_sync_q <= sync_in;
      s1_flag_q <= s1_flag_d;
      s1_en_q   <= en;
      s1_rgb_q  <= i_rgb;
      o_sync_q  <= s1_sync_q;
      o_rgb_q   <= o_rgb_d;
    end
  end

  assign o_rgb     = o_rgb_q;
  assign o_hs      = o_sync_q.hs;
  assign o_vs      = o_sync_q.vs;
  assign o_de      = o_sync_q.de;
  assign box_valid = bv_q;

endmodule
